// File: rtl/uart_pkg.sv
// uart_rx shared package: FSM encodings, frame width, default bit time.
// Optional feature macro: UART_PARITY_EN (even parity bit after the data bits).
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int BIT_TIME_DEF = 2604;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  function automatic logic parity_bad(
    input logic [DATA_BITS-1:0] d,
    input logic                 p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status strobes out.
// Receiver side uses master; the consumer/driver side uses slave.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter with clear; flags half-bit and full-bit terminal counts.
// Used by uart_rx (see uart_pkg for the UART_PARITY_EN option).
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_TIME = BIT_TIME_DEF,
  parameter int CNT_W    = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic half,
  output logic full
);

  localparam int HALF_M1 = BIT_TIME / 2 - 1;
  localparam int FULL_M1 = BIT_TIME - 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign half = (cnt == HALF_M1[CNT_W-1:0]);
  assign full = (cnt == FULL_M1[CNT_W-1:0]);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling, registered valid/error strobes.
// Define UART_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_TIME = BIT_TIME_DEF,
  parameter int CNT_W    = 12
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.master bus
);

  logic                 rx_m;
  logic                 rx_s;
  logic [1:0]           sync_ok;
  logic                 armed;
  logic [2:0]           state;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ferr;
  logic                 half;
  logic                 full;
  logic                 clr;
`ifdef UART_PARITY_EN
  logic                 par;
  logic                 perr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  // rx_s only reflects the real line two clocks after reset;
  // a start edge is accepted only once the line has been seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ok <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync_ok <= {sync_ok[0], 1'b1};
      armed   <= armed | (sync_ok[1] & rx_s);
    end
  end

  assign clr = (state == S_IDLE)
            || (state == S_WAIT_IDLE)
            || ((state == S_START) && half)
            || full;

  uart_bit_timer #(
    .BIT_TIME (BIT_TIME),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .half  (half),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
`ifdef UART_PARITY_EN
      par   <= 1'b0;
      perr  <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
`ifdef UART_PARITY_EN
      perr  <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (armed && !rx_s)
            state <= S_START;
        end
        S_START: begin
          if (half) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              idx   <= '0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (full) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (full) begin
            par   <= rx_s;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (full) begin
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
`ifdef UART_PARITY_EN
              perr  <= parity_bad(shift, par);
`endif
              state <= S_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data;
  assign bus.rx_valid  = valid;
  assign bus.frame_err = ferr;
  assign bus.busy      = (state != S_IDLE);
`ifdef UART_PARITY_EN
  assign bus.parity_err = perr;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BIT_TIME=16.
// Honours UART_PARITY_EN for frame length and parity checks.
module tb_uart_rx;

  localparam int BT = 16;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = (10 + PB) * BT;
  localparam int LAT   = 2 + BT / 2 + (9 + PB) * BT;

  logic clk;
  logic reset;
  uart_rx_if u_if ();

  uart_rx #(
    .BIT_TIME (BT),
    .CNT_W    (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_pv = 0;
  int n_both = 0;
  int v_cyc [0:15];
  logic [7:0] v_data [0:15];
  int start_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      v_cyc[n_valid % 16]  = cyc;
      v_data[n_valid % 16] = u_if.rx_data;
      if (u_if.parity_err) n_pv++;
      n_valid++;
    end
    if (u_if.frame_err) n_ferr++;
    if (u_if.parity_err) n_perr++;
    if (u_if.rx_valid && u_if.frame_err) n_both++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    u_if.rx = v;
    clk_n(BT);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input logic p);
    start_cyc = cyc + 1;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_PARITY_EN
    bit_out(p);
`else
    if (p === 1'bx) u_if.rx = 1'b0;
`endif
    bit_out(stop);
    u_if.rx = 1'b1;
  endtask

  int k0;
  int f0;
  int s0;

  initial begin
    u_if.rx = 1'b1;
    reset = 1'b1;
    clk_n(4);
    reset = 1'b0;
    clk_n(100);
    chk("reset_data", 32'(u_if.rx_data), 32'h0);
    chk("reset_valid", 32'(u_if.rx_valid), 32'h0);
    chk("reset_ferr", 32'(u_if.frame_err), 32'h0);
    chk("reset_perr", 32'(u_if.parity_err), 32'h0);
    chk("reset_busy", 32'(u_if.busy), 32'h0);
    chk("idle_no_strobe", 32'(n_valid + n_ferr), 32'h0);

    // single 0xA5
    k0 = n_valid;
    send_byte(8'hA5, 1'b1, 1'b0);
    clk_n(10);
    chk("a5_count", 32'(n_valid - k0), 32'd1);
    chk("a5_latency", 32'(v_cyc[k0 % 16] - start_cyc), 32'(LAT));
    chk("a5_data", 32'(v_data[k0 % 16]), 32'hA5);
    chk("a5_ferr", 32'(n_ferr), 32'd0);

    // back-to-back 0x00, 0xFF
    k0 = n_valid;
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    clk_n(10);
    chk("b2b_count", 32'(n_valid - k0), 32'd2);
    chk("b2b_data0", 32'(v_data[k0 % 16]), 32'h00);
    chk("b2b_data1", 32'(v_data[(k0 + 1) % 16]), 32'hFF);
    chk("b2b_gap", 32'(v_cyc[(k0 + 1) % 16] - v_cyc[k0 % 16]),
        32'(FRAME));

    // start glitch of 5 clk
    k0 = n_valid;
    f0 = n_ferr;
    u_if.rx = 1'b0;
    clk_n(5);
    chk("glitch_busy_hi", 32'(u_if.busy), 32'd1);
    u_if.rx = 1'b1;
    clk_n(40);
    chk("glitch_busy_lo", 32'(u_if.busy), 32'd0);
    chk("glitch_strobes", 32'(n_valid - k0 + n_ferr - f0), 32'd0);

    // bad stop on 0x3C, line then held low 40 clk
    k0 = n_valid;
    f0 = n_ferr;
    send_byte(8'h3C, 1'b0, 1'b0);
    u_if.rx = 1'b0;
    clk_n(40);
    u_if.rx = 1'b1;
    clk_n(30);
    chk("ferr_count", 32'(n_ferr - f0), 32'd1);
    chk("ferr_no_valid", 32'(n_valid - k0), 32'd0);
    chk("ferr_data_kept", 32'(u_if.rx_data), 32'hFF);
    chk("ferr_busy", 32'(u_if.busy), 32'd0);
    send_byte(8'h11, 1'b1, 1'b0);
    clk_n(10);
    chk("after_ferr_count", 32'(n_valid - k0), 32'd1);
    chk("after_ferr_data", 32'(u_if.rx_data), 32'h11);
    chk("never_both", 32'(n_both), 32'd0);

    // reset in DATA after 4 bits
    k0 = n_valid;
    f0 = n_ferr;
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    u_if.rx = 1'b0;
    clk_n(3);
    chk("pre_rst_busy", 32'(u_if.busy), 32'd1);
    reset = 1'b1;
    clk_n(1);
    chk("rst_data", 32'(u_if.rx_data), 32'h0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    reset = 1'b0;
    u_if.rx = 1'b1;
    clk_n(20);
    chk("rst_no_strobe", 32'(n_valid - k0 + n_ferr - f0), 32'd0);

    // line held low through reset
    reset = 1'b1;
    u_if.rx = 1'b0;
    clk_n(3);
    reset = 1'b0;
    clk_n(60);
    chk("low_rst_busy", 32'(u_if.busy), 32'd0);
    chk("low_rst_strobe", 32'(n_valid - k0 + n_ferr - f0), 32'd0);
    u_if.rx = 1'b1;
    clk_n(20);

    // 0x5A with parity bit 1 (odd overall)
    s0 = n_pv;
    send_byte(8'h5A, 1'b1, 1'b1);
    clk_n(10);
    chk("5a_count", 32'(n_valid - k0), 32'd1);
    chk("5a_data", 32'(u_if.rx_data), 32'h5A);
`ifdef UART_PARITY_EN
    chk("5a_perr_with_valid", 32'(n_pv - s0), 32'd1);
    chk("perr_total", 32'(n_perr), 32'd1);
`else
    chk("perr_tied_low", 32'(n_perr), 32'd0);
`endif
    chk("5a_ferr", 32'(n_ferr - f0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive stage; consumes the synchronized reset produced by the reset synchronizer and drives `rx_data` and `rx_valid` to downstream logic on the Nexys2 board.
- Oversamples the asynchronous serial line with a bit-period counter and samples each bit at mid-bit.
- Frame format: 8N1, LSB first, idle-high line.
- Emits one-cycle strobes for a good byte and for a framing error.

Parameters:
- BIT_TIME, 2604, clk cycles per bit (50 MHz / 19200 baud); must be >= 8.
- CNT_W, 12, counter width; must satisfy 2^CNT_W > BIT_TIME.

Ports:
- clk  input  1  system clock; all logic posedge.
- reset  input  1  synchronous active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle strobe: `rx_data` holds a good byte.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- parity_err  output  1  one-cycle strobe: parity mismatch; constant 0 when UART_PARITY_EN is undefined.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Synchronizer
  - `rx` passes through 2 flops (`rx_s`), which add 2 clk of latency.
  - Reset value of the synchronizer flops is 1.
- Reset
  - Reset values: state=IDLE, counter=0, bit index=0, shift register=0, `rx_data`=0, all strobes=0, `busy`=0.
  - Reset asserted mid-frame aborts the frame with no strobe.
  - After reset, the block waits for `rx_s`=1 before accepting a start edge; a line held low through reset produces no byte.
- IDLE
  - Counter held at 0.
  - `rx_s`=0 -> START.
- START
  - Counter increments each clk.
  - At counter = BIT_TIME/2 - 1 (integer division):
    - `rx_s`=1 -> glitch; back to IDLE, no strobe.
    - `rx_s`=0 -> counter=0, bit index=0, go to DATA.
- DATA
  - Counter increments; at counter = BIT_TIME-1: shift `rx_s` into bit [7] of a right-shift register, counter=0, bit index+1.
  - After the 8th sample (index 7) -> STOP, or PARITY if the macro is defined.
- STOP
  - At counter = BIT_TIME-1, sample `rx_s`.
  - `rx_s`=1: `rx_data` <= shift register, `rx_valid`=1 for 1 clk, -> IDLE.
  - `rx_s`=0: `rx_data` unchanged, `frame_err`=1 for 1 clk, -> WAIT_IDLE.
- WAIT_IDLE
  - Hold until `rx_s`=1 (break or line fault), then -> IDLE.
  - A line stuck low yields exactly one `frame_err`.
- Timing
  - `rx_valid` rises 2 + BIT_TIME/2 + 9*BIT_TIME clk after the falling edge on `rx` (+BIT_TIME with parity).
  - The return to IDLE at mid-stop permits back-to-back frames with zero idle gap.
- Strobes
  - Strobes are registered.
  - `rx_valid` and `frame_err` are never high in the same cycle.
  - `parity_err` may coincide with `rx_valid`; the byte is still delivered.
- `busy` is combinational from state (state != IDLE).

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; one extra bit is sampled at mid-bit.
  - Even parity: the XOR of the 8 data bits plus the parity bit must be 0.
  - On a good stop bit, `parity_err` pulses with `rx_valid` if the parity check failed.
  - On a bad stop bit, only `frame_err` pulses.
- Undefined: no PARITY state; `parity_err` tied 0.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE), 3-bit;
  - DATA_BITS=8;
  - default BIT_TIME.
- One sub-module, `uart_bit_timer`:
  - bit-period counter with clear input;
  - `half` and `full` terminal-count outputs.
- The FSM and shift register stay in `uart_rx`.

Test Plan:
- Reset then idle: `rx`=1 for 100 clk -> all outputs 0, `busy`=0.
- BIT_TIME=16, send 0xA5 -> `rx_valid` pulses once exactly 2+8+144 clk after the start edge; `rx_data`=0xA5; `frame_err`=0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two `rx_valid` pulses, 160 clk apart; `rx_data` 0x00 then 0xFF.
- Start glitch: `rx` low for 5 clk (BIT_TIME=16) -> no strobe; `busy` drops back to 0.
- Stop bit forced low on byte 0x3C, line held low 40 clk -> a single `frame_err` pulse; `rx_data` keeps its previous value; the next good frame 0x11 is received correctly.
- Reset asserted in DATA after 4 bits -> outputs cleared next clk; the following frame 0x5A is received correctly. With UART_PARITY_EN: 0x5A sent with parity bit 1 -> `rx_valid` and `parity_err` in the same cycle.
